// File: rtl/ibus_responder_pkg.sv
// Shared instruction-bus types plus the responder's FSM encoding and latency limit.
package ibus_responder_pkg;

  localparam int IBUS_MAX_LATENCY = 15;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic {
    IDLE,
    WAIT
  } ibus_resp_state_t;

endpackage

// File: rtl/ibus_responder.sv
// Memory-side ibus endpoint: one outstanding fetch, fixed LATENCY from addr_ok to data_ok,
// backed by an external 1-cycle synchronous SRAM.
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int AW      = 12,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  ibus_req_t       ireq,
  output ibus_resp_t      iresp,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     served_cnt
);

  if (LATENCY < 2 || LATENCY > IBUS_MAX_LATENCY) begin : g_bad_latency
    $error("ibus_responder: LATENCY must be in 2..15");
  end

  ibus_resp_state_t state;
  logic [3:0]       cnt;
  logic             first_q;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             accept;
  logic             done;

  assign accept = (state == IDLE) && ireq.valid && !reset;
  // cnt holds through the capture cycle, so it reaches 1 exactly LATENCY cycles after accept.
  assign done   = (state == WAIT) && !first_q && (cnt == 4'd1) && !reset;

  always_comb begin
    iresp         = '0;
    iresp.addr_ok = accept;
    iresp.data_ok = done;
    iresp.data    = data_q;
  end

  assign mem_en   = accept;
  assign mem_addr = accept ? ireq.addr[AW+1:2] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      served_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq.valid) begin
            addr_q  <= ireq.addr;
            cnt     <= 4'(LATENCY - 1);
            first_q <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (first_q) begin
            data_q  <= mem_rdata;
            first_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
          if (!first_q && cnt == 4'd1) begin
            served_cnt <= served_cnt + 32'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/ibus_sram_model.sv
// Behavioural 1-cycle-read SRAM; contents are preloaded hierarchically by the bench.
module ibus_sram_model #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
  end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder at LATENCY 2, 5 and 4.
module tb_ibus_responder;
  import ibus_responder_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ibus_req_t        r2, r5, r4;
  ibus_resp_t       s2, s5, s4;
  logic             en2, en5, en4;
  logic [AW-1:0]    ma2, ma5, ma4;
  logic [31:0]      rd2, rd5, rd4;
  logic [31:0]      sc2, sc5, sc4;

  ibus_responder #(.AW(AW), .LATENCY(2)) u_d2 (
    .clk(clk), .reset(reset), .ireq(r2), .iresp(s2), .mem_en(en2),
    .mem_addr(ma2), .mem_rdata(rd2), .served_cnt(sc2));
  ibus_sram_model #(.AW(AW)) u_m2 (.clk(clk), .en(en2), .addr(ma2), .rdata(rd2));

  ibus_responder #(.AW(AW), .LATENCY(5)) u_d5 (
    .clk(clk), .reset(reset), .ireq(r5), .iresp(s5), .mem_en(en5),
    .mem_addr(ma5), .mem_rdata(rd5), .served_cnt(sc5));
  ibus_sram_model #(.AW(AW)) u_m5 (.clk(clk), .en(en5), .addr(ma5), .rdata(rd5));

  ibus_responder #(.AW(AW), .LATENCY(4)) u_d4 (
    .clk(clk), .reset(reset), .ireq(r4), .iresp(s4), .mem_en(en4),
    .mem_addr(ma4), .mem_rdata(rd4), .served_cnt(sc4));
  ibus_sram_model #(.AW(AW)) u_m4 (.clk(clk), .en(en4), .addr(ma4), .rdata(rd4));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] words5 [3];
  int aok_pulses;

  initial begin
    reset = 1'b1;
    r2 = '{valid: 1'b1, addr: 32'h40};
    r5 = '0;
    r4 = '0;
    u_m2.mem[16] = 32'hDEAD_BEEF;
    u_m2.mem[1]  = 32'h1111_2222;
    u_m5.mem[0]  = 32'hA000_0000;
    u_m5.mem[1]  = 32'hA111_1111;
    u_m5.mem[2]  = 32'hA222_2222;
    u_m4.mem[5]  = 32'h5555_0055;
    words5[0] = 32'hA000_0000;
    words5[1] = 32'hA111_1111;
    words5[2] = 32'hA222_2222;

    // reset held, valid high: handshake outputs must stay low
    cyc(); cyc(); #1;
    chk("rst_addr_ok", 32'(s2.addr_ok), 32'd0);
    chk("rst_mem_en",  32'(en2), 32'd0);
    chk("rst_mem_addr", 32'(ma2), 32'd0);
    chk("rst_data_ok", 32'(s2.data_ok), 32'd0);
    chk("rst_data",    s2.data, 32'd0);
    chk("rst_served",  sc2, 32'd0);

    // idle 5 cycles
    cyc(); reset = 1'b0; r2 = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("idle_outs", {29'd0, s2.addr_ok | s5.addr_ok | s4.addr_ok,
                        s2.data_ok | s5.data_ok | s4.data_ok, en2 | en5 | en4}, 32'd0);
      chk("idle_served", sc2 | sc5 | sc4, 32'd0);
    end

    // LATENCY=2 single fetch of 0x40
    cyc(); r2 = '{valid: 1'b1, addr: 32'h40}; #1;
    chk("l2_addr_ok", 32'(s2.addr_ok), 32'd1);
    chk("l2_mem_en",  32'(en2), 32'd1);
    chk("l2_mem_addr", 32'(ma2), 32'h10);
    chk("l2_dok_T",   32'(s2.data_ok), 32'd0);
    cyc(); r2 = '0; #1;
    chk("l2_dok_T1",  32'(s2.data_ok), 32'd0);
    chk("l2_aok_T1",  32'(s2.addr_ok), 32'd0);
    cyc(); #1;
    chk("l2_dok_T2",  32'(s2.data_ok), 32'd1);
    chk("l2_data",    s2.data, 32'hDEAD_BEEF);
    cyc(); #1;
    chk("l2_dok_T3",  32'(s2.data_ok), 32'd0);
    chk("l2_served",  sc2, 32'd1);
    chk("l2_data_hold", s2.data, 32'hDEAD_BEEF);

    // aliasing: 0x4007 -> word 1
    cyc(); r2 = '{valid: 1'b1, addr: 32'h0000_4007}; #1;
    chk("alias_mem_addr", 32'(ma2), 32'h001);
    cyc(); r2 = '0; cyc(); #1;
    chk("alias_dok",  32'(s2.data_ok), 32'd1);
    chk("alias_data", s2.data, 32'h1111_2222);
    cyc(); #1;
    chk("alias_served", sc2, 32'd2);

    // LATENCY=5 back-to-back with valid held: accepts at 0,6,12, responses at 5,11,17
    aok_pulses = 0;
    for (int c = 0; c < 18; c++) begin
      cyc();
      r5 = '{valid: (c < 13), addr: 32'(4 * (c / 6))};
      #1;
      chk($sformatf("l5_aok_c%0d", c), 32'(s5.addr_ok), 32'((c % 6) == 0));
      chk($sformatf("l5_dok_c%0d", c), 32'(s5.data_ok), 32'((c % 6) == 5));
      if (s5.addr_ok) aok_pulses++;
      if ((c % 6) == 5) chk($sformatf("l5_data_c%0d", c), s5.data, words5[c / 6]);
    end
    r5 = '0;
    cyc(); #1;
    chk("l5_pulses", 32'(aok_pulses), 32'd3);
    chk("l5_served", sc5, 32'd3);

    // LATENCY=4: reset at T+1 drops the request
    cyc(); r4 = '{valid: 1'b1, addr: 32'h14}; #1;
    chk("l4_aok_T", 32'(s4.addr_ok), 32'd1);
    cyc(); r4 = '0; reset = 1'b1; #1;
    chk("l4_rst_dok", 32'(s4.data_ok), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      cyc(); reset = 1'b0; #1;
      chk($sformatf("l4_dropped_T%0d", i), 32'(s4.data_ok), 32'd0);
      chk($sformatf("l4_idle_aok_T%0d", i), 32'(s4.addr_ok), 32'd0);
    end
    chk("l4_rst_data", s4.data, 32'd0);
    chk("l4_rst_served", sc4, 32'd0);
    cyc(); r4 = '{valid: 1'b1, addr: 32'h14}; #1;
    chk("l4_re_aok", 32'(s4.addr_ok), 32'd1);
    cyc(); r4 = '0; #1;
    for (int i = 2; i <= 3; i++) begin
      cyc(); #1;
      chk($sformatf("l4_re_early_T%0d", i), 32'(s4.data_ok), 32'd0);
    end
    cyc(); #1;
    chk("l4_re_dok",  32'(s4.data_ok), 32'd1);
    chk("l4_re_data", s4.data, 32'h5555_0055);
    cyc(); #1;
    chk("l4_re_served", sc4, 32'd1);

    // served_cnt wrap
    force u_d2.served_cnt = 32'hFFFF_FFFF;
    cyc();
    release u_d2.served_cnt;
    #1;
    chk("wrap_pre", sc2, 32'hFFFF_FFFF);
    cyc(); r2 = '{valid: 1'b1, addr: 32'h40};
    cyc(); r2 = '0;
    cyc(); #1;
    chk("wrap_dok", 32'(s2.data_ok), 32'd1);
    cyc(); #1;
    chk("wrap_served", sc2, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
